// File: rtl/cla_slice_scheduler.sv
// Two-requester adder that time-shares a single 4-bit carry-lookahead slice,
// producing one WIDTH-bit sum over NSLICE consecutive ADD cycles.

module cla_slice4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is a flat sum of generate/propagate terms, so no carry ripples inside the slice
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

module cla_slice_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_ptr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_id;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_lastSlice;
  logic [KW+1:0]    w_bitIdx;
  logic [3:0]       w_sliceA;
  logic [3:0]       w_sliceB;
  logic [3:0]       w_sliceSum;
  logic             w_sliceCout;

  // r_ptr remembers the last requester granted; on contention the other one wins
  assign w_grant0 = req0_valid & (~req1_valid | r_ptr);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_ptr);
  assign w_accept = (r_state == IDLE) & (w_grant0 | w_grant1);

  assign w_lastSlice = (r_k == KW'(NSLICE - 1));
  assign w_bitIdx    = {r_k, 2'b00};
  assign w_sliceA    = r_a[w_bitIdx +: 4];
  assign w_sliceB    = r_b[w_bitIdx +: 4];

  cla_slice4 u_slice (
    .i_a    (w_sliceA),
    .i_b    (w_sliceB),
    .i_cin  (r_carry),
    .o_sum  (w_sliceSum),
    .o_cout (w_sliceCout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 | w_grant1) begin
          w_nextState = ADD;
        end
      end
      ADD: begin
        if (w_lastSlice) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured only at acceptance, so requester inputs are ignored afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_ptr   <= 1'b1;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? req1_a : req0_a;
            r_b     <= w_grant1 ? req1_b : req0_b;
            r_carry <= w_grant1 ? req1_cin : req0_cin;
            r_id    <= w_grant1;
            r_ptr   <= w_grant1;
            r_k     <= '0;
          end
        end
        ADD: begin
          r_sum[w_bitIdx +: 4] <= w_sliceSum;
          r_carry              <= w_sliceCout;
          if (w_lastSlice) begin
            r_cout <= w_sliceCout;
            r_k    <= '0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cla_slice_scheduler.sv
// Randomised scoreboard bench for cla_slice_scheduler: a cycle-level model of
// arbitration/latency plus a queue of arithmetic results checked by a monitor.

module tb_cla_slice_scheduler;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         c0 = 1'b0, c1 = 1'b0;
  logic         rspReady = 1'b1;

  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  cla_slice_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v0),
    .req0_a     (a0),
    .req0_b     (b0),
    .req0_cin   (c0),
    .req0_ready (req0_ready),
    .req1_valid (v1),
    .req1_a     (a1),
    .req1_b     (b1),
    .req1_cin   (c1),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ready  (rspReady),
    .busy       (busy)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   vecCount   = 0;
  int   errCount   = 0;
  int   cycleNo    = 0;
  int   mAcceptCyc = 0;
  bit   mBusy      = 1'b0;
  bit   mLast      = 1'b1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic reportTimeout(input string name);
    vecCount++;
    errCount++;
    $display("[TB] FAIL %s: bound expired, got no completion, expected completion (cycle %0d)", name, cycleNo);
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t     r;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.id   = id;
    r.sum  = full[W-1:0];
    r.cout = full[W];
    return r;
  endfunction

  task automatic setReq(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (id == 0) begin
      a0 = a; b0 = b; c0 = cin; v0 = 1'b1;
    end else begin
      a1 = a; b1 = b; c1 = cin; v1 = 1'b1;
    end
  endtask

  task automatic newOp(input int id);
    logic [W-1:0] a, b;
    a = W'($urandom);
    b = W'($urandom);
    if ($urandom_range(0, 7) == 0) a = '1;
    if ($urandom_range(0, 7) == 0) b = '0;
    setReq(id, a, b, 1'($urandom_range(0, 1)));
  endtask

  // One clock cycle: check handshake outputs mid-cycle against the model, then advance
  task automatic stepCycle(output logic [1:0] acc);
    bit expDone, r0, r1;
    @(negedge clk);
    expDone = mBusy && (cycleNo - mAcceptCyc >= NSLICE + 1);
    r0 = !mBusy && v0 && (!v1 || mLast);
    r1 = !mBusy && v1 && (!v0 || !mLast);
    checkOutput("req0_ready", req0_ready, r0);
    checkOutput("req1_ready", req1_ready, r1);
    checkOutput("busy", busy, mBusy);
    checkOutput("rsp_valid", rsp_valid, expDone);
    acc = {r1, r0};
    if (r0) begin
      expQ.push_back(model(1'b0, a0, b0, c0));
      mLast = 1'b0; mBusy = 1'b1; mAcceptCyc = cycleNo;
    end else if (r1) begin
      expQ.push_back(model(1'b1, a1, b1, c1));
      mLast = 1'b1; mBusy = 1'b1; mAcceptCyc = cycleNo;
    end else if (expDone && rspReady) begin
      mBusy = 1'b0;
    end
    @(posedge clk);
    #1;
    cycleNo++;
    if (r0) v0 = 1'b0;
    if (r1) v1 = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rspReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mBusy = 1'b0; mLast = 1'b1;
    expQ.delete();
    cycleNo++;
  endtask

  task automatic drain();
    logic [1:0] acc;
    rspReady = 1'b1;
    for (int i = 0; i < 80 && (mBusy || v0 || v1); i++) stepCycle(acc);
    if (mBusy || v0 || v1) reportTimeout("drain");
  endtask

  task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input int bpCycles);
    logic [1:0] acc;
    bit         done;
    int         bpLeft;
    bpLeft = bpCycles;
    rspReady = 1'b1;
    setReq(id, a, b, cin);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      stepCycle(acc);
      done = acc[id];
    end
    if (!done) reportTimeout("accept");
    if (bpCycles > 0) newOp(1 - id);
    for (int i = 0; i < 40 && mBusy; i++) begin
      if ((cycleNo - mAcceptCyc >= NSLICE + 1) && bpLeft > 0) begin
        rspReady = 1'b0;
        bpLeft--;
      end else begin
        rspReady = 1'b1;
      end
      stepCycle(acc);
    end
    if (mBusy) reportTimeout("complete");
  endtask

  // Monitor: whenever a result is presented it must match the oldest outstanding one
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (expQ.size() == 0) begin
        vecCount++;
        errCount++;
        $display("[TB] FAIL rsp_unexpected: got rsp_valid=1, expected no response (cycle %0d)", cycleNo);
      end else begin
        monExp = expQ[0];
        checkOutput("rsp_id", rsp_id, monExp.id);
        checkOutput("rsp_sum", rsp_sum, monExp.sum);
        checkOutput("rsp_cout", rsp_cout, monExp.cout);
        if (rspReady) expQ.delete(0);
      end
    end
  end

  initial begin
    logic [1:0] acc;
    int         accepts;
    bit         done;

    doReset();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_sum", rsp_sum, 0);
    checkOutput("reset_rsp_cout", rsp_cout, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_req0_ready", req0_ready, 0);
    checkOutput("reset_req1_ready", req1_ready, 0);

    // Contention straight out of reset, both requesters held valid
    accepts = 0;
    for (int i = 0; i < 80 && accepts < 3; i++) begin
      if (!v0) newOp(0);
      if (!v1) newOp(1);
      stepCycle(acc);
      accepts += int'(acc[0]) + int'(acc[1]);
    end
    if (accepts < 3) reportTimeout("contention");
    drain();

    $display("[TB] directed adds");
    applyStimulus(0, 16'h24D9, 16'h0C10, 1'b0, 0);
    applyStimulus(1, 16'hFDE8, 16'h0C10, 1'b0, 0);
    applyStimulus(0, 16'hFFFF, 16'h0000, 1'b1, 0);
    applyStimulus(1, 16'h0000, 16'h0000, 1'b0, 0);

    $display("[TB] back-pressure");
    applyStimulus(0, 16'h8765, 16'h789A, 1'b1, 3);
    drain();

    $display("[TB] reset mid-operation");
    setReq(1, 16'h1357, 16'h2468, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      stepCycle(acc);
      done = acc[1];
    end
    if (!done) reportTimeout("accept_before_abort");
    stepCycle(acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mBusy = 1'b0; mLast = 1'b1;
    expQ.delete();
    cycleNo++;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_rsp_sum", rsp_sum, 0);
    checkOutput("abort_rsp_id", rsp_id, 0);
    newOp(0);
    newOp(1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (!v0 && $urandom_range(0, 3) == 0) newOp(0);
      else if (v0 && $urandom_range(0, 15) == 0) v0 = 1'b0;
      if (!v1 && $urandom_range(0, 3) == 0) newOp(1);
      else if (v1 && $urandom_range(0, 15) == 0) v1 = 1'b0;
      rspReady = ($urandom_range(0, 3) != 0);
      stepCycle(acc);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    drain();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
